// File: rtl/approx_div_32by16.sv
`default_nettype none
// ============================================================================
//  Module      : approx_div_32by16
//  Description : Sequential restoring divider, 32-bit dividend / 16-bit
//                divisor -> 16-bit quotient and 16-bit remainder. One
//                quotient bit per cycle, valid/ready on both sides, one
//                transaction in flight at a time.
//
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                in_valid/in_ready  - request handshake (in_ready = IDLE)
//                dividend, divisor  - operands, sampled on the accept edge
//                out_valid/out_ready- result handshake
//                quotient, remainder- result, held until out_ready
//                ovf                - quotient does not fit / divide by zero
//
//  Config      : APPROX_DIV_EN - when defined, only 12 iterations run;
//                quotient = {q[11:0], 4'b0000}, remainder forced to zero.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_div_32by16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        ovf
);

`ifdef APPROX_DIV_EN
    localparam logic [3:0] c_LAST_ITER = 4'd11;
`else
    localparam logic [3:0] c_LAST_ITER = 4'd15;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;      // partial remainder R (bit 16 is always 0 between iterations)
    logic [15:0] quo_q, quo_d;      // shifts out dividend bits, shifts in quotient bits
    logic [15:0] div_q, div_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        ovf_q, ovf_d;
    logic        out_valid_q, out_valid_d;

    // One restoring step: shift {R,Q} left, trial-subtract D at 17 bits.
    logic [16:0] w_shift_r;
    logic        w_ge;
    logic [15:0] w_rem_next;
    logic [15:0] w_quo_next;

    assign w_shift_r  = {rem_q, quo_q[15]};
    assign w_ge       = (w_shift_r >= {1'b0, div_q});
    // After a successful subtract the result is below D, so 16 bits suffice.
    assign w_rem_next = w_ge ? 16'(w_shift_r - {1'b0, div_q}) : w_shift_r[15:0];
    assign w_quo_next = {quo_q[14:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d = divisor;
                    rem_d = dividend[31:16];
                    quo_d = dividend[15:0];
                    cnt_d = '0;
                    // High half >= divisor means the quotient needs more than
                    // 16 bits; this also catches divisor == 0.
                    if (dividend[31:16] >= divisor) begin
                        quotient_d  = 16'hFFFF;
                        remainder_d = 16'h0000;
                        ovf_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = w_rem_next;
                quo_d = w_quo_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == c_LAST_ITER) begin
`ifdef APPROX_DIV_EN
                    // Low 12 bits of Q hold floor(dividend[31:4] / divisor).
                    quotient_d  = {w_quo_next[11:0], 4'b0000};
                    remainder_d = 16'h0000;
`else
                    quotient_d  = w_quo_next;
                    remainder_d = w_rem_next;
`endif
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire
